// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-master data-memory arbiter: FSM states and master indices.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef logic master_idx_t;

  localparam master_idx_t MASTER_CPU = 1'b0;
  localparam master_idx_t MASTER_DBG = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-request round-robin picker; the last-granted pointer lives in the caller.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic [1:0]  req_i,
  input  master_idx_t last_i,
  output logic        gnt_valid_o,
  output master_idx_t gnt_idx_o
);

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_idx_o   = MASTER_CPU;
    if (&req_i) begin
      // Tie: the master that did not win last time goes next.
      gnt_idx_o = ~last_i;
    end else if (req_i[1]) begin
      gnt_idx_o = MASTER_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter/sequencer for the single-port data memory (IDLE -> ACCESS -> RESP).
// Define DMEM_ARB_ALIGN_CHECK_EN to reject misaligned or out-of-range accesses with err_o.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              err_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_writedata_o,
  output logic              mem_memread_o,
  output logic              mem_memwrite_o,
  input  logic [DATA_W-1:0] mem_readdata_i
);

  if (DEPTH_WORDS < 1) begin : g_bad_depth
    $error("dmem_arbiter: DEPTH_WORDS must be at least 1");
  end

  state_e            state_q, state_d;
  master_idx_t       last_q, last_d;
  master_idx_t       gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              rej_q, rej_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              gnt_valid;
  master_idx_t       gnt_idx;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_reject;

  rr_arbiter2 u_rr_arbiter2 (
    .req_i       ({m1_req_i, m0_req_i}),
    .last_i      (last_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign win_we    = (gnt_idx == MASTER_DBG) ? m1_we_i    : m0_we_i;
  assign win_addr  = (gnt_idx == MASTER_DBG) ? m1_addr_i  : m0_addr_i;
  assign win_wdata = (gnt_idx == MASTER_DBG) ? m1_wdata_i : m0_wdata_i;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign win_reject = (win_addr[1:0] != 2'b00) ||
                      ((win_addr >> 2) >= ADDR_W'(DEPTH_WORDS));
`else
  assign win_reject = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    rej_d    = rej_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err_d    = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = ACCESS;
          gnt_d   = gnt_idx;
          last_d  = gnt_idx;
          addr_d  = win_addr;
          wdata_d = win_wdata;
          rd_d    = ~win_we & ~win_reject;
          wr_d    = win_we & ~win_reject;
          rej_d   = win_reject;
        end
      end
      ACCESS: begin
        // rd_q is only set for accepted reads, so writes and rejects return 0.
        rdata0_d = (rd_q && gnt_q == MASTER_CPU) ? mem_readdata_i : '0;
        rdata1_d = (rd_q && gnt_q == MASTER_DBG) ? mem_readdata_i : '0;
        ack0_d   = (gnt_q == MASTER_CPU);
        ack1_d   = (gnt_q == MASTER_DBG);
        err_d    = rej_q;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        state_d  = RESP;
      end
      RESP: begin
        // Address and write data stay put so they outlive the write strobe.
        rdata0_d = '0;
        rdata1_d = '0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      last_q   <= MASTER_DBG;
      gnt_q    <= MASTER_CPU;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rej_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      rej_q    <= rej_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign m0_ack_o        = ack0_q;
  assign m1_ack_o        = ack1_q;
  assign m0_rdata_o      = rdata0_q;
  assign m1_rdata_o      = rdata1_q;
  assign err_o           = err_q;
  assign busy_o          = (state_q != IDLE);
  assign mem_addr_o      = addr_q;
  assign mem_writedata_o = wdata_q;
  assign mem_memread_o   = rd_q;
  assign mem_memwrite_o  = wr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with an 8-word memory model.
// Build with DMEM_ARB_ALIGN_CHECK_EN defined to also exercise the rejection path.
module tb_dmem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic        m0_ack_o, m1_ack_o, err_o, busy_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic [31:0] mem_addr_o, mem_writedata_o, mem_readdata_i;
  logic        mem_memread_o, mem_memwrite_o;

  logic [31:0] mem [8];
  int          checks = 0;
  int          errors = 0;

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(8)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .m0_req_i        (m0_req_i),
    .m0_we_i         (m0_we_i),
    .m0_addr_i       (m0_addr_i),
    .m0_wdata_i      (m0_wdata_i),
    .m0_ack_o        (m0_ack_o),
    .m0_rdata_o      (m0_rdata_o),
    .m1_req_i        (m1_req_i),
    .m1_we_i         (m1_we_i),
    .m1_addr_i       (m1_addr_i),
    .m1_wdata_i      (m1_wdata_i),
    .m1_ack_o        (m1_ack_o),
    .m1_rdata_o      (m1_rdata_o),
    .err_o           (err_o),
    .busy_o          (busy_o),
    .mem_addr_o      (mem_addr_o),
    .mem_writedata_o (mem_writedata_o),
    .mem_memread_o   (mem_memread_o),
    .mem_memwrite_o  (mem_memwrite_o),
    .mem_readdata_i  (mem_readdata_i)
  );

  // Memory model: combinational read, write while the strobe is high at an edge.
  assign mem_readdata_i = mem[mem_addr_o[4:2]];
  always @(posedge clk_i) begin
    if (mem_memwrite_o && (mem_addr_o >> 2) < 32'd8) mem[mem_addr_o[4:2]] <= mem_writedata_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One isolated transaction starting from IDLE; ends back in IDLE.
  task automatic single(input bit m, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input bit exp_err, input string tag);
    if (m) begin
      m1_req_i = 1'b1; m1_we_i = we; m1_addr_i = addr; m1_wdata_i = wdata;
    end else begin
      m0_req_i = 1'b1; m0_we_i = we; m0_addr_i = addr; m0_wdata_i = wdata;
    end
    step();
    check({tag, "_memread"},  32'(mem_memread_o),  32'(!we && !exp_err));
    check({tag, "_memwrite"}, 32'(mem_memwrite_o), 32'(we && !exp_err));
    check({tag, "_addr"}, mem_addr_o, addr);
    if (we) check({tag, "_wdata"}, mem_writedata_o, wdata);
    check({tag, "_busy"}, 32'(busy_o), 32'd1);
    check({tag, "_early_ack"}, 32'(m0_ack_o | m1_ack_o), 32'd0);
    step();
    check({tag, "_strobes_off"}, 32'(mem_memread_o | mem_memwrite_o), 32'd0);
    check({tag, "_addr_held"}, mem_addr_o, addr);
    check({tag, "_ack"}, 32'(m ? m1_ack_o : m0_ack_o), 32'd1);
    check({tag, "_other_ack"}, 32'(m ? m0_ack_o : m1_ack_o), 32'd0);
    check({tag, "_rdata"}, m ? m1_rdata_o : m0_rdata_o, exp_rd);
    check({tag, "_other_rdata"}, m ? m0_rdata_o : m1_rdata_o, 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'(exp_err));
    $display("txn %s m%0d we=%0d addr=0x%08h rdata=0x%08h err=%0d", tag, m, we, addr,
             m ? m1_rdata_o : m0_rdata_o, err_o);
    m0_req_i = 1'b0;
    m1_req_i = 1'b0;
    step();
    check({tag, "_ack_done"}, 32'(m0_ack_o | m1_ack_o), 32'd0);
    check({tag, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int n;
    int last_cyc;
    bit exp_m;
    bit g;
    bit seen;

    for (int i = 0; i < 8; i++) mem[i] = 32'd0;
    mem[3] = 32'hDEADBEEF;
    rst_i = 1'b0;
    m0_req_i = 1'b0; m0_we_i = 1'b0; m0_addr_i = '0; m0_wdata_i = '0;
    m1_req_i = 1'b0; m1_we_i = 1'b0; m1_addr_i = '0; m1_wdata_i = '0;
    step();
    step();
    rst_i = 1'b1;
    step();
    check("rst_outputs", {m0_rdata_o | m1_rdata_o | mem_addr_o | mem_writedata_o}, 32'd0);
    check("rst_ctrl", 32'({m0_ack_o, m1_ack_o, err_o, busy_o, mem_memread_o, mem_memwrite_o}), 32'd0);

    // Basic read, write, read-back.
    single(1'b0, 1'b0, 32'h0C, 32'h0, 32'hDEADBEEF, 1'b0, "rd0c");
    single(1'b1, 1'b1, 32'h10, 32'h12345678, 32'h0, 1'b0, "wr10");
    check("mem_word4", mem[4], 32'h12345678);
    single(1'b0, 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0, "rd10");

    // m1 raises its request during m0's RESP: held off until the next IDLE sample.
    m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 32'h0C;
    step();
    step();
    check("hold_m0_ack", 32'(m0_ack_o), 32'd1);
    m0_req_i = 1'b0;
    m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h10;
    step();
    check("hold_idle_busy", 32'(busy_o), 32'd0);
    check("hold_idle_read", 32'(mem_memread_o), 32'd0);
    step();
    check("hold_m1_read", 32'(mem_memread_o), 32'd1);
    check("hold_m1_addr", mem_addr_o, 32'h10);
    step();
    check("hold_m1_ack", 32'(m1_ack_o), 32'd1);
    check("hold_m1_rdata", m1_rdata_o, 32'h12345678);
    $display("txn hold m1 rdata=0x%08h", m1_rdata_o);
    m1_req_i = 1'b0;
    step();

    // Both masters request continuously; m1 won last, so m0 goes first.
    m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 32'h0C;
    m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h10;
    n = 0; last_cyc = -1; exp_m = 1'b0;
    for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
      step();
      if (m0_ack_o && m1_ack_o) begin
        check("rr_overlap", 32'd1, 32'd0);
      end else if (m0_ack_o || m1_ack_o) begin
        g = m1_ack_o;
        check("rr_order", 32'(g), 32'(exp_m));
        if (last_cyc >= 0) check("rr_gap", 32'(cyc - last_cyc), 32'd3);
        check("rr_rdata", g ? m1_rdata_o : m0_rdata_o, g ? 32'h12345678 : 32'hDEADBEEF);
        $display("txn rr #%0d m%0d cycle %0d", n, g, cyc);
        exp_m = ~exp_m;
        last_cyc = cyc;
        n++;
        if (n == 8) begin
          m0_req_i = 1'b0;
          m1_req_i = 1'b0;
        end
      end
    end
    check("rr_count", 32'(n), 32'd8);
    step();

    // Asynchronous reset in the middle of a write's ACCESS cycle.
    m0_req_i = 1'b1; m0_we_i = 1'b1; m0_addr_i = 32'h1C; m0_wdata_i = 32'hAAAA5555;
    step();
    check("rst_wr_strobe_on", 32'(mem_memwrite_o), 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check("rst_wr_strobe_off", 32'(mem_memwrite_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    m0_req_i = 1'b0;
    step();
    rst_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (m0_ack_o || m1_ack_o) seen = 1'b1;
    end
    check("rst_no_ack", 32'(seen), 32'd0);
    check("rst_mem_untouched", mem[7], 32'd0);
    $display("txn reset-abort write 0x1C");
    m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 32'h0C;
    m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h10;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (m0_ack_o || m1_ack_o) begin
        seen = 1'b1;
        check("rst_first_tie_m0", 32'({m1_ack_o, m0_ack_o}), 32'b01);
        $display("txn post-reset tie m%0d", m1_ack_o);
      end
    end
    check("rst_tie_seen", 32'(seen), 32'd1);
    m0_req_i = 1'b0;
    m1_req_i = 1'b0;
    step();

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    single(1'b0, 1'b1, 32'h0E, 32'hCAFEF00D, 32'h0, 1'b1, "misaligned_wr");
    check("misaligned_mem", mem[3], 32'hDEADBEEF);
    single(1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, "oor_rd");
    single(1'b1, 1'b0, 32'h1C, 32'h0, 32'h0, 1'b0, "last_word_rd");
`else
    single(1'b1, 1'b0, 32'h0E, 32'h0, 32'hDEADBEEF, 1'b0, "unchecked_rd");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
